// File: rtl/adl3_inverse_scan_if.sv
// rtl/adl3_inverse_scan_if.sv - start/result bundle for the ADL3 inverse scanner
//   start       : master -> slave, one-cycle scan request
//   target[2:0] : master -> slave, pattern {f1,f2,f3} captured with start
//   busy        : slave -> master, scan in progress
//   done        : slave -> master, one-cycle pulse when results are valid
//   match_mask  : slave -> master, bit k set when code k matches
//   match_count : slave -> master, number of matching codes (0..16)
//   first_idx   : slave -> master, lowest matching code (0 if none)
//   found       : slave -> master, at least one code matched
interface adl3_inverse_scan_if;
  logic        start;
  logic [2:0]  target;
  logic        busy;
  logic        done;
  logic [15:0] match_mask;
  logic [4:0]  match_count;
  logic [3:0]  first_idx;
  logic        found;

  modport master (
    output start, target,
    input  busy, done, match_mask, match_count, first_idx, found
  );

  modport slave (
    input  start, target,
    output busy, done, match_mask, match_count, first_idx, found
  );
endinterface

// File: rtl/adl3_inverse_scan.sv
// rtl/adl3_inverse_scan.sv - scans A=0..15 of the ADL3 table for codes producing a target pattern
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : adl3_inverse_scan_if.slave (start/target in, busy/done/results out)
//   DWELL : cycles spent on each code, 1..8
//   ADL3_DONT_CARE_MATCH_EN : when defined, x table entries match either target bit;
//                             otherwise x entries are treated as 0
module adl3_inverse_scan #(
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  adl3_inverse_scan_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] DWELL_LAST = 3'(DWELL - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  dwell_q, dwell_d;
  logic [2:0]  target_q, target_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  first_q, first_d;
  logic        found_q, found_d;

  logic [2:0]  code_val;
  logic        code_match;

  // Table value for the current code with every x entry written as 0.
  always_comb begin
    code_val = 3'b000;
    case (idx_q)
      4'd1:    code_val = 3'b100;
      4'd3:    code_val = 3'b011;
      4'd4:    code_val = 3'b101;
      4'd5:    code_val = 3'b110;
      4'd7:    code_val = 3'b110;
      4'd11:   code_val = 3'b001;
      4'd13:   code_val = 3'b101;
      4'd15:   code_val = 3'b001;
      default: code_val = 3'b000;
    endcase
  end

`ifdef ADL3_DONT_CARE_MATCH_EN
  logic [2:0] code_dc;

  // Positions of the x entries; those bits are excluded from the compare.
  always_comb begin
    code_dc = 3'b000;
    case (idx_q)
      4'd3:    code_dc = 3'b100;
      4'd5:    code_dc = 3'b001;
      4'd6:    code_dc = 3'b110;
      4'd9:    code_dc = 3'b001;
      4'd14:   code_dc = 3'b001;
      default: code_dc = 3'b000;
    endcase
  end

  assign code_match = ((code_val ^ target_q) & ~code_dc) == 3'b000;
`else
  assign code_match = (code_val == target_q);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    target_d = target_q;
    mask_d   = mask_q;
    count_d  = count_q;
    first_d  = first_q;
    found_d  = found_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SCAN;
          target_d = bus.target;
          mask_d   = 16'h0000;
          count_d  = 5'd0;
          first_d  = 4'd0;
          found_d  = 1'b0;
          idx_d    = 4'd0;
          dwell_d  = 3'd0;
        end
      end
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = 3'd0;
          if (code_match) begin
            mask_d[idx_q] = 1'b1;
            count_d       = count_q + 5'd1;
            if (!found_q) begin
              first_d = idx_q;
              found_d = 1'b1;
            end
          end
          // idx parks at 15 after the last code rather than wrapping.
          if (idx_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          dwell_d = dwell_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      dwell_q  <= 3'd0;
      target_q <= 3'd0;
      mask_q   <= 16'h0000;
      count_q  <= 5'd0;
      first_q  <= 4'd0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      first_q  <= first_d;
      found_q  <= found_d;
    end
  end

  assign bus.busy        = (state_q == ST_SCAN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.match_mask  = mask_q;
  assign bus.match_count = count_q;
  assign bus.first_idx   = first_q;
  assign bus.found       = found_q;

endmodule
